switch_allocator_param: RTL and testbench

- Parametrised five-port router switch allocator. Ports: UP, DOWN, LEFT, RIGHT, PE.
- Serves NUM_VC virtual channels by internal time-slot rotation. No external VC enable is used.
- Routes each head flit by dimension order (XY or YX) and decrements its hop field.
- Each output/VC pair has its own round-robin arbiter. Output writes are registered and guarded against stale-empty double writes.
- Sits between the per-port input VC buffers and the output VC buffers of each mesh node.

---
 rtl/switch_allocator_param_if.sv | 40 ++++
 rtl/switch_allocator_param.sv | 177 +++++++++++++++++
 tb/tb_switch_allocator_param.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/switch_allocator_param_if.sv
// Bus bundle between a switch allocator and its neighbouring VC buffers.
// Entry k = v*5 + p selects VC v of port p (0 UP, 1 DOWN, 2 LEFT, 3 RIGHT, 4 PE).
//   in_valid   input buffer k holds a flit
//   in_data    flit of input buffer k, slice [k*DATA_W +: DATA_W]
//   in_clear   pulse frees input buffer k at the next edge
//   out_empty  output buffer k is empty
//   out_enable registered write strobe into output buffer k
//   out_data   registered flit written into output buffer k
// The master modport is the allocator; the slave modport is the buffer side.
interface switch_allocator_param_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned NUM_VC = 2
);
  localparam int unsigned NumK = 5 * NUM_VC;

  logic [NumK-1:0]        in_valid;
  logic [NumK*DATA_W-1:0] in_data;
  logic [NumK-1:0]        in_clear;
  logic [NumK-1:0]        out_empty;
  logic [NumK-1:0]        out_enable;
  logic [NumK*DATA_W-1:0] out_data;

  modport master (
    input  in_valid,
    input  in_data,
    input  out_empty,
    output in_clear,
    output out_enable,
    output out_data
  );

  modport slave (
    output in_valid,
    output in_data,
    output out_empty,
    input  in_clear,
    input  out_enable,
    input  out_data
  );
endinterface

// File: rtl/switch_allocator_param.sv
// Five-port mesh router switch allocator with time-slotted virtual channels.
// Each cycle one VC (vc_sel_o) is served: every valid head flit of that VC is routed by
// dimension order (XY or YX), its hop field is decremented, and a per-output/per-VC
// round-robin arbiter picks one input per available output. The winning flit is written
// to the output buffer one cycle later; the input is cleared combinationally.
// Ports:
//   clk_i        clock
//   rst_ni       asynchronous active-low reset
//   bus          switch_allocator_param_if.master (input/output buffer handshake)
//   vc_sel_o     VC served this cycle
//   err_uturn_o  sticky flag: a U-turn flit was dropped
module switch_allocator_param #(
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned HOP_W      = 4,
  parameter int unsigned NUM_VC     = 2,
  parameter int unsigned ROUTE_MODE = 0,
  localparam int unsigned VcW       = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  switch_allocator_param_if.master    bus,
  output logic [VcW-1:0]              vc_sel_o,
  output logic                        err_uturn_o
);

  localparam int unsigned NumPorts = 5;
  localparam int unsigned NumK     = NumPorts * NUM_VC;
  localparam int unsigned DirXBit  = DATA_W - 2;
  localparam int unsigned DirYBit  = DATA_W - 3;
  localparam int unsigned HopXTop  = DATA_W - 9;
  localparam int unsigned HopYTop  = DATA_W - 9 - HOP_W;

  localparam logic [2:0] PortUp    = 3'd0;
  localparam logic [2:0] PortDown  = 3'd1;
  localparam logic [2:0] PortLeft  = 3'd2;
  localparam logic [2:0] PortRight = 3'd3;
  localparam logic [2:0] PortPe    = 3'd4;

  // State
  logic [VcW-1:0]         vc_q, vc_d;
  logic                   err_q, err_d;
  logic [NumK-1:0]        out_en_q, out_en_d;
  logic [NumK*DATA_W-1:0] out_data_q, out_data_d;
  logic [2:0]             ptr_q [NumPorts][NUM_VC];
  logic [2:0]             ptr_d [NumPorts][NUM_VC];

  // Per-port routing results for the served VC
  int unsigned            base;
  logic [DATA_W-1:0]      flit_in  [NumPorts];
  logic [DATA_W-1:0]      flit_out [NumPorts];
  logic [HOP_W-1:0]       hop_x    [NumPorts];
  logic [HOP_W-1:0]       hop_y    [NumPorts];
  logic [2:0]             tgt      [NumPorts];
  logic [NumPorts-1:0]    vld;
  logic [NumPorts-1:0]    uturn;

  // Arbitration; req[o][p] means input p wants output o
  logic [NumPorts-1:0]    req      [NumPorts];
  logic [NumPorts-1:0]    avail;
  logic [NumPorts-1:0]    gnt_vld;
  logic [2:0]             gnt_port [NumPorts];
  logic [NumPorts-1:0]    granted;

  assign base = NumPorts * 32'(vc_q);

  // Dimension-order routing and hop decrement
  always_comb begin
    for (int p = 0; p < NumPorts; p++) begin
      vld[p]      = bus.in_valid[base + p];
      flit_in[p]  = bus.in_data[(base + p) * DATA_W +: DATA_W];
      hop_x[p]    = flit_in[p][HopXTop -: HOP_W];
      hop_y[p]    = flit_in[p][HopYTop -: HOP_W];
      flit_out[p] = flit_in[p];
      tgt[p]      = PortPe;
      if (ROUTE_MODE == 0) begin
        if (hop_x[p] != '0) begin
          flit_out[p][HopXTop -: HOP_W] = hop_x[p] - 1'b1;
          tgt[p] = flit_in[p][DirXBit] ? PortLeft : PortRight;
        end else if (hop_y[p] != '0) begin
          flit_out[p][HopYTop -: HOP_W] = hop_y[p] - 1'b1;
          tgt[p] = flit_in[p][DirYBit] ? PortUp : PortDown;
        end
      end else begin
        if (hop_y[p] != '0) begin
          flit_out[p][HopYTop -: HOP_W] = hop_y[p] - 1'b1;
          tgt[p] = flit_in[p][DirYBit] ? PortUp : PortDown;
        end else if (hop_x[p] != '0) begin
          flit_out[p][HopXTop -: HOP_W] = hop_x[p] - 1'b1;
          tgt[p] = flit_in[p][DirXBit] ? PortLeft : PortRight;
        end
      end
      // Sending a flit back where it came from is illegal, except PE loopback
      uturn[p] = vld[p] && (tgt[p] == 3'(p)) && (3'(p) != PortPe);
    end
  end

  // Request matrix and output availability
  always_comb begin
    for (int o = 0; o < NumPorts; o++) begin
      // A write issued last cycle blocks the slot until the empty flag catches up
      avail[o] = bus.out_empty[base + o] & ~out_en_q[base + o];
      for (int p = 0; p < NumPorts; p++) begin
        req[o][p] = vld[p] & ~uturn[p] & (tgt[p] == 3'(o));
      end
    end
  end

  // Round-robin arbitration per output for the served VC
  always_comb begin
    int unsigned cand;
    cand    = 0;
    ptr_d   = ptr_q;
    gnt_vld = '0;
    granted = '0;
    for (int o = 0; o < NumPorts; o++) begin
      gnt_port[o] = '0;
      for (int i = 0; i < NumPorts; i++) begin
        cand = 32'(ptr_q[o][vc_q]) + 32'(i);
        if (cand >= NumPorts) cand = cand - NumPorts;
        if (avail[o] && !gnt_vld[o] && req[o][cand]) begin
          gnt_vld[o]  = 1'b1;
          gnt_port[o] = 3'(cand);
        end
      end
      if (gnt_vld[o]) begin
        granted[gnt_port[o]] = 1'b1;
        ptr_d[o][vc_q] = (gnt_port[o] == PortPe) ? 3'd0 : gnt_port[o] + 3'd1;
      end
    end
  end

  // Next-state for writes, VC rotation, sticky error and input clears
  always_comb begin
    out_en_d   = '0;
    out_data_d = '0;
    err_d      = err_q | (|uturn);
    vc_d       = (vc_q == VcW'(NUM_VC - 1)) ? '0 : vc_q + 1'b1;
    bus.in_clear = '0;
    for (int o = 0; o < NumPorts; o++) begin
      if (gnt_vld[o]) begin
        out_en_d[base + o] = 1'b1;
        out_data_d[(base + o) * DATA_W +: DATA_W] = flit_out[gnt_port[o]];
      end
    end
    if (rst_ni) begin
      for (int p = 0; p < NumPorts; p++) begin
        bus.in_clear[base + p] = uturn[p] | granted[p];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vc_q       <= '0;
      err_q      <= 1'b0;
      out_en_q   <= '0;
      out_data_q <= '0;
      for (int o = 0; o < NumPorts; o++) begin
        for (int v = 0; v < NUM_VC; v++) begin
          ptr_q[o][v] <= '0;
        end
      end
    end else begin
      vc_q       <= vc_d;
      err_q      <= err_d;
      out_en_q   <= out_en_d;
      out_data_q <= out_data_d;
      ptr_q      <= ptr_d;
    end
  end

  assign bus.out_enable = out_en_q;
  assign bus.out_data   = out_data_q;
  assign vc_sel_o       = vc_q;
  assign err_uturn_o    = err_q;

endmodule

// File: tb/tb_switch_allocator_param.sv
// Directed bench: an XY instance with two VCs and a YX instance with one VC.
module tb_switch_allocator_param;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  switch_allocator_param_if #(.DATA_W(64), .NUM_VC(2)) ifa ();
  switch_allocator_param_if #(.DATA_W(64), .NUM_VC(1)) ifb ();

  logic vca, vcb, erra, errb;

  switch_allocator_param #(
    .DATA_W(64), .HOP_W(4), .NUM_VC(2), .ROUTE_MODE(0)
  ) u_dut_xy (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .bus        (ifa),
    .vc_sel_o   (vca),
    .err_uturn_o(erra)
  );

  switch_allocator_param #(
    .DATA_W(64), .HOP_W(4), .NUM_VC(1), .ROUTE_MODE(1)
  ) u_dut_yx (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .bus        (ifb),
    .vc_sel_o   (vcb),
    .err_uturn_o(errb)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Flit builder: DIR_X=62, DIR_Y=61, HOP_X=[55:52], HOP_Y=[51:48], marker bits elsewhere
  function automatic logic [63:0] mk(input logic dx, input logic dy, input logic [3:0] hx,
                                     input logic [3:0] hy, input logic [31:0] pl);
    logic [63:0] f;
    f = '0;
    f[63] = 1'b1;
    f[62] = dx;
    f[61] = dy;
    f[58] = 1'b1;
    f[55:52] = hx;
    f[51:48] = hy;
    f[47:32] = 16'hA5C3;
    f[31:0] = pl;
    return f;
  endfunction

  task automatic set_a(input int k, input logic [63:0] f);
    ifa.in_valid[k] = 1'b1;
    ifa.in_data[k*64 +: 64] = f;
  endtask

  task automatic set_b(input int k, input logic [63:0] f);
    ifb.in_valid[k] = 1'b1;
    ifb.in_data[k*64 +: 64] = f;
  endtask

  task automatic wait_vc0();
    int n;
    n = 0;
    while (vca !== 1'b0 && n < 4) begin
      @(negedge clk);
      n++;
    end
    check("wait_vc0", 64'(vca), 64'd0);
  endtask

  logic [63:0] fl [4];

  initial begin
    // Reset with random stimulus
    for (int i = 0; i < 20; i++) ifa.in_data[i*32 +: 32] = $urandom;
    for (int i = 0; i < 10; i++) ifb.in_data[i*32 +: 32] = $urandom;
    ifa.in_valid  = 10'($urandom);
    ifa.out_empty = 10'($urandom);
    ifb.in_valid  = 5'($urandom) | 5'h10;
    ifb.out_empty = 5'h1f;
    repeat (3) @(negedge clk);
    #1;
    check("rst_en_a", 64'(ifa.out_enable), 64'd0);
    check("rst_data_a", 64'(|ifa.out_data), 64'd0);
    check("rst_clr_a", 64'(ifa.in_clear), 64'd0);
    check("rst_vc_a", 64'(vca), 64'd0);
    check("rst_err_a", 64'(erra), 64'd0);
    check("rst_en_b", 64'(ifb.out_enable), 64'd0);
    check("rst_clr_b", 64'(ifb.in_clear), 64'd0);

    ifa.in_valid = '0; ifa.out_empty = '1; ifa.in_data = '0;
    ifb.in_valid = '0; ifb.out_empty = '1; ifb.in_data = '0;
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("vc_seq0", 64'(vca), 64'd0);
    @(negedge clk); check("vc_seq1", 64'(vca), 64'd1);
    @(negedge clk); check("vc_seq2", 64'(vca), 64'd0);
    @(negedge clk); check("vc_seq3", 64'(vca), 64'd1);

    // XY route: PE VC0, hop_x=3, DIR_X=0 -> RIGHT VC0, hop_x=2
    @(negedge clk);
    wait_vc0();
    set_a(4, mk(1'b0, 1'b0, 4'd3, 4'd0, 32'h1111_0001));
    #1 check("xy_clear", 64'(ifa.in_clear), 64'h010);
    @(negedge clk);
    ifa.in_valid[4] = 1'b0;
    check("xy_en", 64'(ifa.out_enable), 64'h008);
    check("xy_data", ifa.out_data[3*64 +: 64], mk(1'b0, 1'b0, 4'd2, 4'd0, 32'h1111_0001));
    @(negedge clk);
    check("xy_en_drop", 64'(ifa.out_enable), 64'd0);
    check("xy_data_zero", ifa.out_data[3*64 +: 64], 64'd0);

    // Contention on PE output VC0: UP, DOWN, LEFT, RIGHT every VC0 slot
    wait_vc0();
    for (int i = 0; i < 4; i++) begin
      fl[i] = mk(1'b0, 1'b0, 4'd0, 4'd0, 32'h2222_0000 + 32'(i));
      set_a(i, fl[i]);
    end
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("cont_clear%0d", i), 64'(ifa.in_clear), 64'(10'd1 << i));
      @(negedge clk);
      check($sformatf("cont_en%0d", i), 64'(ifa.out_enable), 64'h010);
      check($sformatf("cont_data%0d", i), ifa.out_data[4*64 +: 64], fl[i]);
      ifa.in_valid[i] = 1'b0;
      @(negedge clk);
      #1;
    end
    // Pointer now at PE: PE loopback wins over UP
    set_a(0, mk(1'b0, 1'b0, 4'd0, 4'd0, 32'h3333_0000));
    set_a(4, mk(1'b0, 1'b0, 4'd0, 4'd0, 32'h3333_0004));
    #1 check("ptr_pe_first", 64'(ifa.in_clear), 64'h010);
    @(negedge clk);
    check("loop_data", ifa.out_data[4*64 +: 64], mk(1'b0, 1'b0, 4'd0, 4'd0, 32'h3333_0004));
    ifa.in_valid[4] = 1'b0;
    @(negedge clk);
    #1 check("ptr_up_next", 64'(ifa.in_clear), 64'h001);
    @(negedge clk);
    check("up_data", ifa.out_data[4*64 +: 64], mk(1'b0, 1'b0, 4'd0, 4'd0, 32'h3333_0000));
    ifa.in_valid[0] = 1'b0;
    check("loop_no_err", 64'(erra), 64'd0);

    // VC1: DOWN routes to UP, LEFT is a U-turn
    check("vc1_slot", 64'(vca), 64'd1);
    set_a(6, mk(1'b0, 1'b1, 4'd0, 4'd2, 32'h4444_0006));
    set_a(7, mk(1'b1, 1'b0, 4'd1, 4'd0, 32'h4444_0007));
    #1 check("vc1_clear", 64'(ifa.in_clear), 64'h0C0);
    check("err_before", 64'(erra), 64'd0);
    @(negedge clk);
    ifa.in_valid[6] = 1'b0;
    ifa.in_valid[7] = 1'b0;
    check("vc1_en", 64'(ifa.out_enable), 64'h020);
    check("vc1_data", ifa.out_data[5*64 +: 64], mk(1'b0, 1'b1, 4'd0, 4'd1, 32'h4444_0006));
    check("uturn_err", 64'(erra), 64'd1);
    repeat (3) @(negedge clk);
    check("uturn_sticky", 64'(erra), 64'd1);
    check("uturn_no_write", 64'(ifa.out_enable), 64'd0);

    // Reset during a granted cycle discards the pending write
    wait_vc0();
    set_a(4, mk(1'b0, 1'b0, 4'd1, 4'd0, 32'h5555_0004));
    #1 check("mid_clear", 64'(ifa.in_clear), 64'h010);
    rst_n = 1'b0;
    #1 check("mid_clear_rst", 64'(ifa.in_clear), 64'd0);
    check("mid_err_cleared", 64'(erra), 64'd0);
    @(negedge clk);
    check("mid_en_discard", 64'(ifa.out_enable), 64'd0);
    ifa.in_valid = '0;
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_en_after", 64'(ifa.out_enable), 64'd0);
    check("mid_vc_after", 64'(vca), 64'd1);

    // YX instance: hop_x=1, hop_y=2, DIR_Y=1 -> UP with hop_y=1
    set_b(4, mk(1'b0, 1'b1, 4'd1, 4'd2, 32'h6666_0004));
    #1 check("yx_clear", 64'(ifb.in_clear), 64'h10);
    @(negedge clk);
    ifb.in_valid[4] = 1'b0;
    check("yx_en", 64'(ifb.out_enable), 64'h01);
    check("yx_data", ifb.out_data[0 +: 64], mk(1'b0, 1'b1, 4'd1, 4'd1, 32'h6666_0004));
    check("yx_vc", 64'(vcb), 64'd0);

    // Backpressure on RIGHT, then two flits to RIGHT at t and t+2
    ifb.out_empty = 5'b10111;
    set_b(0, mk(1'b0, 1'b0, 4'd1, 4'd0, 32'h7777_000A));
    #1 check("bp_no_clear", 64'(ifb.in_clear), 64'd0);
    @(negedge clk);
    check("bp_no_en", 64'(ifb.out_enable), 64'd0);
    ifb.out_empty = 5'h1f;
    set_b(1, mk(1'b0, 1'b0, 4'd1, 4'd0, 32'h7777_000B));
    #1 check("bp_gnt_t", 64'(ifb.in_clear), 64'h01);
    @(negedge clk);
    ifb.in_valid[0] = 1'b0;
    check("bp_en_a", 64'(ifb.out_enable), 64'h08);
    check("bp_data_a", ifb.out_data[3*64 +: 64], mk(1'b0, 1'b0, 4'd0, 4'd0, 32'h7777_000A));
    #1 check("bp_blocked_t1", 64'(ifb.in_clear), 64'd0);
    @(negedge clk);
    #1 check("bp_gnt_t2", 64'(ifb.in_clear), 64'h02);
    check("bp_gap", 64'(ifb.out_enable), 64'd0);
    @(negedge clk);
    ifb.in_valid[1] = 1'b0;
    check("bp_en_b", 64'(ifb.out_enable), 64'h08);
    check("bp_data_b", ifb.out_data[3*64 +: 64], mk(1'b0, 1'b0, 4'd0, 4'd0, 32'h7777_000B));
    check("b_no_err", 64'(errb), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
